seven_seg_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display. Takes a packed BCD value, latches it once per frame, and scans one digit at a time: it selects the active anode and decodes that digit's nibble into segment levels. Sits directly downstream of the design's BCD sources and upstream of the board's anode and cathode pins; the per-digit decode is the existing `BCD_to_sevenSeg` module.

---
 rtl/seven_seg_pkg.sv | 13 +
 rtl/BCD_to_sevenSeg.sv | 28 ++
 rtl/seven_seg_scan_driver.sv | 128 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver: scan state
// encoding, the blank segment pattern and the default prescaler divide.
package seven_seg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK        = 7'h7F;
    localparam int         TICK_DIV_DEFAULT = 100_000;

endpackage

// File: rtl/BCD_to_sevenSeg.sv
// BCD nibble to common-anode segment levels (active-low, bit 6 = a .. bit 0 = g).
// Codes 10..15 produce the blank pattern.
module BCD_to_sevenSeg
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup; the caller registers the result.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = 7'h01;
            4'd1:    o_seg = 7'h4F;
            4'd2:    o_seg = 7'h12;
            4'd3:    o_seg = 7'h06;
            4'd4:    o_seg = 7'h4C;
            4'd5:    o_seg = 7'h24;
            4'd6:    o_seg = 7'h20;
            4'd7:    o_seg = 7'h0F;
            4'd8:    o_seg = 7'h00;
            4'd9:    o_seg = 7'h04;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver.
// A prescaler produces one tick per digit slot; the packed BCD value and
// digit enables are latched into a shadow copy once per frame so a digit
// never changes mid-frame. All outputs are registered.
// Optional leading-zero blanking is built when SEVEN_SEG_LZ_BLANK_EN is defined.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   bcd_value,
    input  logic [N_DIGITS-1:0]     digit_en,
    output logic [N_DIGITS-1:0]     anodes,
    output logic [6:0]              segments,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);

    scan_state_t            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [4*N_DIGITS-1:0]  r_shadow;
    logic [N_DIGITS-1:0]    r_en;
    logic [N_DIGITS-1:0]    r_anodes;
    logic [6:0]             r_segments;
    logic                   r_frame_start;

    logic                   w_tick;
    logic                   w_wrap;
    logic                   w_load;
    logic [IDX_W-1:0]       w_idx_next;
    logic [N_DIGITS-1:0]    w_en_load;
    logic [4*N_DIGITS-1:0]  w_shadow_next;
    logic [N_DIGITS-1:0]    w_en_next;
    logic [3:0]             w_nibble;
    logic                   w_digit_on;
    logic [6:0]             w_seg_dec;
    logic [N_DIGITS-1:0]    w_anode_sel;

    assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    // The first tick after reset is treated as a wrap so the shadow loads
    // before digit 0 is ever lit.
    assign w_wrap     = (r_state == IDLE) || (r_idx == IDX_W'(N_DIGITS - 1));
    assign w_load     = w_tick && w_wrap;
    assign w_idx_next = w_wrap ? '0 : r_idx + 1'b1;

    // Enables as they will be latched; leading-zero blanking walks down
    // from the top digit and never touches digit 0.
    always_comb begin
        w_en_load = digit_en;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        begin : lz_blank
            logic w_zero_above;
            w_zero_above = 1'b1;
            for (int k = N_DIGITS - 1; k >= 1; k--) begin
                w_zero_above = w_zero_above && (bcd_value[4*k +: 4] == 4'd0);
                if (w_zero_above) begin
                    w_en_load[k] = 1'b0;
                end
            end
        end
`endif
    end

    // Output values must reflect a shadow load happening on the same tick.
    assign w_shadow_next = w_load ? bcd_value : r_shadow;
    assign w_en_next     = w_load ? w_en_load : r_en;
    assign w_nibble      = w_shadow_next[{w_idx_next, 2'b00} +: 4];
    assign w_digit_on    = w_en_next[w_idx_next] && (w_nibble <= 4'd9);
    assign w_anode_sel   = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << w_idx_next);

    BCD_to_sevenSeg u_bcd_to_seven_seg (
        .i_bcd (w_nibble),
        .o_seg (w_seg_dec)
    );

    // Prescaler: one tick every TICK_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Scan FSM: digit index, frame shadow and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_en          <= '0;
            r_anodes      <= '1;
            r_segments    <= SEG_BLANK;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            if (w_tick) begin
                r_state <= SCAN;
                r_idx   <= w_idx_next;
                if (w_load) begin
                    r_shadow <= bcd_value;
                    r_en     <= w_en_load;
                end
                if (w_digit_on) begin
                    r_anodes   <= w_anode_sel;
                    r_segments <= w_seg_dec;
                end else begin
                    r_anodes   <= '1;
                    r_segments <= SEG_BLANK;
                end
            end
        end
    end

    assign anodes      = r_anodes;
    assign segments    = r_segments;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (N_DIGITS=8, TICK_DIV=4).
// Expected frames are written as a 32-bit display image: one nibble per
// digit, 4'hF meaning the digit must be dark in its slot.
module tb_seven_seg_scan_driver;

    localparam int ND = 8;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   bcd_value = 32'h87654321;
    logic [7:0]    digit_en = 8'hFF;
    logic [7:0]    anodes;
    logic [6:0]    segments;
    logic          frame_start;

    int n_cmp = 0;
    int n_err = 0;
    int frames_pushed = 0;
    int frames_checked = 0;
    bit mon_busy = 0;

    typedef struct {
        logic [31:0] disp;
        int          id;
    } frame_exp_t;

    frame_exp_t q[$];

    seven_seg_scan_driver #(.N_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk         (clk),
        .reset       (reset),
        .bcd_value   (bcd_value),
        .digit_en    (digit_en),
        .anodes      (anodes),
        .segments    (segments),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h01;
            4'd1: return 7'h4F;
            4'd2: return 7'h12;
            4'd3: return 7'h06;
            4'd4: return 7'h4C;
            4'd5: return 7'h24;
            4'd6: return 7'h20;
            4'd7: return 7'h0F;
            4'd8: return 7'h00;
            4'd9: return 7'h04;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        if (!frame_start) check("frame_start_timeout", 32'd0, 32'd1);
    endtask

    // Drive new inputs `delay` cycles into the next frame; they are captured
    // at the following wrap, so the expectation belongs to the frame after.
    task automatic apply(input logic [31:0] bcd, input logic [7:0] en,
                         input int delay, input logic [31:0] disp, input int id);
        frame_exp_t e;
        wait_fs();
        repeat (delay) @(negedge clk);
        bcd_value = bcd;
        digit_en  = en;
        e.disp = disp;
        e.id   = id;
        q.push_back(e);
        frames_pushed++;
    endtask

    // Monitor: on each frame_start with a pending expectation, check all
    // eight slots and the frame period.
    initial begin
        frame_exp_t e;
        bit at_fs;
        logic [3:0] nib;
        logic [31:0] disp;
        at_fs = 0;
        forever begin
            if (!at_fs) @(negedge clk);
            at_fs = 0;
            if (!reset && frame_start && q.size() > 0) begin
                mon_busy = 1;
                e = q.pop_front();
                disp = e.disp;
                for (int s = 0; s < ND; s++) begin
                    if (s > 0) repeat (TD) @(negedge clk);
                    nib = disp[4*s +: 4];
                    if (nib == 4'hF) begin
                        check($sformatf("f%0d_s%0d_anodes", e.id, s), {24'd0, anodes}, 32'hFF);
                        check($sformatf("f%0d_s%0d_segs", e.id, s), {25'd0, segments}, 32'h7F);
                    end else begin
                        check($sformatf("f%0d_s%0d_anodes", e.id, s), {24'd0, anodes},
                              {24'd0, ~(8'b1 << s)});
                        check($sformatf("f%0d_s%0d_segs", e.id, s), {25'd0, segments},
                              {25'd0, seg_of(nib)});
                    end
                    if (s > 0) check($sformatf("f%0d_s%0d_fs_low", e.id, s), {31'd0, frame_start}, 32'd0);
                end
                repeat (TD) @(negedge clk);
                check($sformatf("f%0d_period", e.id), {31'd0, frame_start}, 32'd1);
                frames_checked++;
                at_fs = 1;
                mon_busy = 0;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int n;
        // Power-on reset, then let scanning run a little.
        repeat (3) @(negedge clk);
        check("reset_anodes", {24'd0, anodes}, 32'hFF);
        check("reset_segs", {25'd0, segments}, 32'h7F);
        check("reset_fs", {31'd0, frame_start}, 32'd0);
        reset = 1'b0;
        repeat (13) @(negedge clk);

        // Mid-scan reset: outputs must go dark without a clock edge.
        #1 reset = 1'b1;
        #1;
        check("async_reset_anodes", {24'd0, anodes}, 32'hFF);
        check("async_reset_segs", {25'd0, segments}, 32'h7F);
        check("async_reset_fs", {31'd0, frame_start}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= TD; c++) begin
            @(negedge clk);
            check($sformatf("restart_fs_c%0d", c), {31'd0, frame_start}, (c == TD) ? 32'd1 : 32'd0);
        end
        check("restart_anodes", {24'd0, anodes}, 32'hFE);
        check("restart_segs", {25'd0, segments}, 32'h4F);

        // Scan order and decode.
        apply(32'h87654321, 8'hFF, 2, 32'h87654321, 1);
        // Tearing: frame of 1s, then change to 2s while digit 3 of that frame is lit.
        apply(32'h11111111, 8'hFF, 2, 32'h11111111, 2);
        apply(32'h22222222, 8'hFF, 13, 32'h22222222, 3);
        // Enables and invalid code on digit 2.
        apply(32'h87654E21, 8'h0F, 2, 32'hFFFF4F21, 4);
`ifdef SEVEN_SEG_LZ_BLANK_EN
        apply(32'h00000305, 8'hFF, 2, 32'hFFFFF305, 5);
        apply(32'h00000000, 8'hFF, 2, 32'hFFFFFFF0, 6);
`else
        apply(32'h00000305, 8'hFF, 2, 32'h00000305, 5);
        apply(32'h00000000, 8'hFF, 2, 32'h00000000, 6);
`endif

        n = 0;
        while ((q.size() != 0 || mon_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("frames_checked", frames_checked, frames_pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
